// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: load/store requester for the single-port RAM, with in-order
// responses through a pending stage and a 2-entry response FIFO.
// Ports: clk, rst_n; req_* (valid/ready request in); rsp_* (valid/ready
// response out); mem_* (RAM port, one-cycle read latency).
// Optional: define MEM_REQ_CTRL_ERR_EN to enable range/alignment checks.
module mem_req_ctrl #(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32,
  parameter int MemSizeBytes = 2048
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AddrBusWidth-1:0] req_addr,
  input  logic [DataBusWidth-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataBusWidth-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [AddrBusWidth-1:0] mem_addr,
  output logic [DataBusWidth-1:0] mem_wdata,
  input  logic [DataBusWidth-1:0] mem_rdata
);

  localparam int ByteLanes = DataBusWidth / 8;
  localparam int WordShift = $clog2(ByteLanes);
  localparam int EntW      = DataBusWidth + 1;

  logic                    accept;
  logic                    req_err;
  logic                    p_valid;
  logic                    p_we;
  logic                    p_err;
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [1:0]              count;
  logic [2:0]              outstanding;
  logic [EntW-1:0]         fifo [2];
  logic [DataBusWidth-1:0] p_rdata;
  logic [EntW-1:0]         p_ent;
  logic [EntW-1:0]         head;
  logic                    fifo_pop;
  logic                    p_pop;
  logic                    p_push;

`ifdef MEM_REQ_CTRL_ERR_EN
  localparam logic [AddrBusWidth-1:0] LowMask =
    AddrBusWidth'(ByteLanes - 1);
  localparam logic [AddrBusWidth-1:0] MemTop =
    AddrBusWidth'(MemSizeBytes);

  assign req_err = (req_addr >= MemTop) |
                   (|(req_addr & LowMask));
`else
  assign req_err = 1'b0;
`endif

  // Credits are counted from state only, so ready never
  // waits on the consumer or the producer this cycle.
  assign count       = wr_ptr - rd_ptr;
  assign outstanding = {1'b0, count} + {2'b00, p_valid};
  assign req_ready   = rst_n & (outstanding < 3'd2);

  assign accept    = req_valid & req_ready;
  assign mem_re    = accept & ~req_we & ~req_err;
  assign mem_we    = accept & req_we & ~req_err;
  assign mem_addr  = req_addr >> WordShift;
  assign mem_wdata = req_wdata;

  // RAM data is only meaningful for a good read; masking
  // also keeps rsp_rdata at 0 while idle or in reset.
  assign p_rdata = (p_valid & ~p_we & ~p_err) ?
                   mem_rdata : '0;
  assign p_ent   = {p_rdata, p_err};

  assign head      = (count != 2'd0) ? fifo[rd_ptr[0]] : p_ent;
  assign rsp_valid = (count != 2'd0) | p_valid;
  assign rsp_rdata = head[EntW-1:1];
  assign rsp_err   = head[0];

  assign fifo_pop = rsp_ready & (count != 2'd0);
  assign p_pop    = rsp_ready & p_valid & (count == 2'd0);
  assign p_push   = p_valid & ~p_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_we    <= 1'b0;
      p_err   <= 1'b0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      p_valid <= accept;
      p_we    <= accept & req_we;
      p_err   <= accept & req_err;
      if (p_push) begin
        fifo[wr_ptr[0]] <= p_ent;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed and randomised checks of mem_req_ctrl
// against a read-first one-cycle RAM model and a shadow reference memory.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] ram   [0:511];
  logic [31:0] model [0:511];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(
    .AddrBusWidth(32),
    .DataBusWidth(32),
    .MemSizeBytes(2048)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr[8:0]];
    if (mem_we) ram[mem_addr[8:0]] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rst_mem_re got=%b exp=0", mem_re); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    step();
    req_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    model[4] = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy0 got=%b exp=1", req_ready); end
    checks++; if ({mem_we, mem_re, mem_addr, mem_wdata} !== {2'b10, 32'h4, 32'hDEADBEEF}) begin errors++; $display("FAIL b2b_wr_port got=%b%b %h %h exp=10 4 deadbeef", mem_we, mem_re, mem_addr, mem_wdata); end
    step();
    req_we = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL b2b_ack got=%b%b %h exp=10 0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if ({req_ready, mem_re, mem_we, mem_addr} !== {3'b110, 32'h4}) begin errors++; $display("FAIL b2b_rd1_port got=%b%b%b %h exp=110 4", req_ready, mem_re, mem_we, mem_addr); end
    step();
    req_addr = 32'h14;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL b2b_rd1 got=%b%b %h exp=10 deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if ({req_ready, mem_re, mem_addr} !== {2'b11, 32'h5}) begin errors++; $display("FAIL b2b_rd2_port got=%b%b %h exp=11 5", req_ready, mem_re, mem_addr); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hA5A50005}) begin errors++; $display("FAIL b2b_rd2 got=%b%b %h exp=10 a5a50005", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy3 got=%b exp=1", req_ready); end
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    step();
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy0 got=%b exp=1", req_ready); end
    step();
    req_addr = 32'h24;
    @(negedge clk);
    checks++; if ({req_ready, rsp_valid, rsp_rdata} !== {2'b11, 32'hA5A50008}) begin errors++; $display("FAIL bp_c1 got=%b%b %h exp=11 a5a50008", req_ready, rsp_valid, rsp_rdata); end
    step();
    req_addr = 32'h28;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got=%b exp=0", req_ready); end
    checks++; if ({mem_re, rsp_valid, rsp_rdata} !== {2'b01, 32'hA5A50008}) begin errors++; $display("FAIL bp_c2 got=%b%b %h exp=01 a5a50008", mem_re, rsp_valid, rsp_rdata); end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_rdy got=%b exp=0", req_ready); end
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA5A50008}) begin errors++; $display("FAIL bp_drain1 got=%b %h exp=1 a5a50008", rsp_valid, rsp_rdata); end
    step();
    @(negedge clk);
    checks++; if ({req_ready, mem_re, mem_addr} !== {2'b11, 32'hA}) begin errors++; $display("FAIL bp_third got=%b%b %h exp=11 a", req_ready, mem_re, mem_addr); end
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA5A50009}) begin errors++; $display("FAIL bp_drain2 got=%b %h exp=1 a5a50009", rsp_valid, rsp_rdata); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA5A5000A}) begin errors++; $display("FAIL bp_rsp3 got=%b %h exp=1 a5a5000a", rsp_valid, rsp_rdata); end
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b exp=0", rsp_valid); end
  endtask

`ifdef MEM_REQ_CTRL_ERR_EN
  task automatic test_error();
    step();
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h800;
    @(negedge clk);
    checks++; if ({req_ready, mem_re, mem_we} !== 3'b100) begin errors++; $display("FAIL err_oor_port got=%b%b%b exp=100", req_ready, mem_re, mem_we); end
    step();
    req_we = 1'b1; req_addr = 32'h3; req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if ({req_ready, mem_re, mem_we} !== 3'b100) begin errors++; $display("FAIL err_mis_port got=%b%b%b exp=100", req_ready, mem_re, mem_we); end
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_oor_rsp got=%b%b %h exp=11 0", rsp_valid, rsp_err, rsp_rdata); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_mis_rsp got=%b%b %h exp=11 0", rsp_valid, rsp_err, rsp_rdata); end
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_idle got=%b exp=0", rsp_valid); end
  endtask
`else
  task automatic test_err_disabled();
    step();
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3;
    @(negedge clk);
    checks++; if ({mem_re, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL noerr_port got=%b %h exp=1 0", mem_re, mem_addr); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hA5A50000}) begin errors++; $display("FAIL noerr_rsp got=%b%b %h exp=10 a5a50000", rsp_valid, rsp_err, rsp_rdata); end
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL noerr_idle got=%b exp=0", rsp_valid); end
  endtask
`endif

  task automatic test_reset_mid();
    step();
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
    step();
    req_addr = 32'h34;
    step();
    req_addr = 32'h38;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, req_ready, mem_re, mem_we} !== 4'b0000) begin errors++; $display("FAIL rmid_async got=%b%b%b%b exp=0000", rsp_valid, req_ready, mem_re, mem_we); end
    step();
    req_valid = 1'b0; rsp_ready = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rmid_release got=%b%b exp=01", rsp_valid, req_ready); end
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got=%b exp=0", rsp_valid); end
    step();
    req_valid = 1'b1; req_addr = 32'h38;
    @(negedge clk);
    checks++; if ({mem_re, mem_addr} !== {1'b1, 32'hE}) begin errors++; $display("FAIL rmid_rd_port got=%b %h exp=1 e", mem_re, mem_addr); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hA5A5000E}) begin errors++; $display("FAIL rmid_rd got=%b%b %h exp=10 a5a5000e", rsp_valid, rsp_err, rsp_rdata); end
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_random();
    int acc = 0;
    int rsp = 0;
    int cyc = 0;
    int maxo = 0;
    int idx;
    logic [32:0] expq[$];
    logic [32:0] got;
    logic [32:0] ex;
    logic took = 1'b0;
    logic err;
    req_valid = 1'b0;
    while ((acc < 1000 || rsp < acc) && cyc < 20000) begin
      step();
      cyc++;
      if (took) req_valid = 1'b0;
      took = 1'b0;
      rsp_ready = 1'($urandom_range(0, 1));
      if (!req_valid && acc < 1000 && $urandom_range(0, 3) != 0) begin
        req_we    = 1'($urandom_range(0, 1));
        req_wdata = $urandom;
        req_addr  = 32'($urandom_range(0, 511)) << 2;
`ifdef MEM_REQ_CTRL_ERR_EN
        case ($urandom_range(0, 9))
          0: req_addr = 32'h800 + (32'($urandom_range(0, 1023)) << 2);
          1: req_addr = req_addr | 32'($urandom_range(1, 3));
          default: ;
        endcase
`endif
        req_valid = 1'b1;
      end
      @(negedge clk);
      if (acc - rsp > maxo) maxo = acc - rsp;
      if (rsp_valid && rsp_ready) begin
        got = {rsp_rdata, rsp_err};
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got=%h exp=none", got);
        end else begin
          ex = expq.pop_front();
          if (got !== ex) begin
            errors++;
            $display("FAIL rand_rsp%0d got=%h exp=%h", rsp, got, ex);
          end
        end
        rsp++;
      end
      if (req_valid && req_ready) begin
        err = 1'b0;
`ifdef MEM_REQ_CTRL_ERR_EN
        err = (req_addr >= 32'h800) || (req_addr[1:0] != 2'b00);
`endif
        idx = int'(req_addr[10:2]);
        if (req_we || err) expq.push_back({32'h0, err});
        else expq.push_back({model[idx], 1'b0});
        if (req_we && !err) model[idx] = req_wdata;
        acc++;
        took = 1'b1;
      end
    end
    step();
    req_valid = 1'b0;
    checks++; if (!(acc == 1000 && rsp == acc)) begin errors++; $display("FAIL rand_timeout got=acc%0d rsp%0d exp=1000 1000", acc, rsp); end
    checks++; if (maxo > 2) begin errors++; $display("FAIL rand_credit got=%0d exp<=2", maxo); end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rand_left got=%0d exp=0", expq.size()); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]   = {16'hA5A5, 16'(i)};
      model[i] = {16'hA5A5, 16'(i)};
    end
    test_reset();
    test_back_to_back();
    test_backpressure();
`ifdef MEM_REQ_CTRL_ERR_EN
    test_error();
`else
    test_err_disabled();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Requester-side controller for the single-port RAM block. It accepts load/store requests from a core pipeline over a valid/ready channel, drives the RAM's `re`/`we`/`addr`/`w_data` port, and captures the one-cycle-latency `r_data`. It returns exactly one in-order response per request over a second valid/ready channel. A 2-entry response buffer absorbs response back-pressure without losing read data.

## Interface
- `AddrBusWidth`, 32, width of byte address on request side and of `mem_addr`
- `DataBusWidth`, 32, data width; multiple of 8, power of two
- `MemSizeBytes`, 2048, RAM size in bytes; requests at or above this are out of range

- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept request
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  AddrBusWidth  byte address
- `req_wdata`  in  DataBusWidth  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_rdata`  out  DataBusWidth  read data; 0 for writes and errors
- `rsp_err`  out  1  request was out of range or misaligned
- `mem_re`, `mem_we`  out  1  RAM read/write enable
- `mem_addr`  out  AddrBusWidth  RAM word index
- `mem_wdata`  out  DataBusWidth  RAM write data
- `mem_rdata`  in  DataBusWidth  RAM read data, valid the cycle after `mem_re`

## Operation
- Accept occurs when `req_valid & req_ready`. Word index = `req_addr >> log2(DataBusWidth/8)`.
- Error condition: `req_addr >= MemSizeBytes`, or the low `log2(DataBusWidth/8)` address bits are non-zero.
- On a good accept: `mem_re = !req_we`, `mem_we = req_we`, `mem_addr = word index`, `mem_wdata = req_wdata`. These are combinational in the accept cycle.
- On an error accept: `mem_re` and `mem_we` stay 0, so the RAM is never touched.
- Pending stage: registers `p_valid`, `p_we` and `p_err` are loaded on each accept and cleared when there is no accept.
- Buffer: 2-entry FIFO of `{rdata, err}` with a pointer-based `count` of 0..2.
- Response head is the FIFO head if `count > 0`; otherwise it is the pending stage.
- Pending stage data is `{p_we|p_err ? 0 : mem_rdata, p_err}`. `rsp_valid = (count > 0) | p_valid`.
- When `p_valid` is set and the pending entry is not consumed this cycle, it is pushed into the FIFO.
- `req_ready = rst_n & ((count + p_valid) < 2)`. It depends only on state, never on `rsp_ready` or `req_valid`.
- Credit invariant: outstanding entries (`count + p_valid`) never exceed 2, so a FIFO push never meets a full FIFO. Verification asserts this.
- Responses are strictly in request order; reads, writes and errors share the single path.

## Timing
- Read accepted in cycle T: `mem_re` high in T; `mem_rdata` sampled in T+1.
- Earliest `rsp_valid` is T+1, driven from the pending stage.
- Write accepted in T: `mem_we` high in T; write ack (`rsp_valid`, `rdata` 0) in T+1.
- Throughput: 1 request/cycle sustained while `rsp_ready` stays high.
- With `rsp_ready` low: two requests are accepted, then `req_ready` drops. It rises the cycle after a response pop frees a credit.
- Simultaneous push and pop in the same cycle: `count` is unchanged and the data order is preserved.
- RAM write mode is read-first. A read issued the cycle after a write to the same word returns the new data.
- Reset values while `rst_n` is low: `p_valid` 0, `count` 0, `rsp_valid` 0, `req_ready` 0, `mem_re` 0, `mem_we` 0, `rsp_err` 0, `rsp_rdata` 0.
- Reset asserted mid-operation discards all outstanding responses immediately. Issued RAM writes are not rolled back.
- The first accept is possible on the first rising edge after `rst_n` deasserts.

## Configuration
- `MEM_REQ_CTRL_ERR_EN` defined: range and alignment checks active as described.
- Not defined:
  - No checks are made; `rsp_err` is constant 0.
  - Address low bits are dropped silently.
  - `mem_addr` is the word index, truncated to the RAM's address range by the RAM itself.
  - Every request reaches the RAM.

## Test plan
- Back-to-back reads: write 0xDEADBEEF @0x10, then read @0x10 and @0x14 with `rsp_ready` high.
  - Responses: ack(0), 0xDEADBEEF, then the contents of @0x14.
  - Each response arrives one cycle after its accept; `req_ready` stays 1 throughout.
- Back-pressure: `rsp_ready` = 0, issue 3 reads.
  - Only 2 are accepted and `req_ready` = 0 after the second.
  - Raising `rsp_ready` drains both responses in order, then the third read is accepted.
- Error (`MEM_REQ_CTRL_ERR_EN` defined): read @0x800 and write @0x3.
  - Each gets `rsp_err` = 1 and `rsp_rdata` = 0.
  - `mem_re` and `mem_we` are never asserted for these requests.
- Error disabled (macro undefined): read @0x3 returns the word @0x0 with `rsp_err` = 0.
- Simultaneous push/pop: random `rsp_ready` toggling over 1000 mixed requests.
  - Responses match a reference model in order.
  - `count + p_valid` never exceeds 2.
- Reset mid-burst: pull `rst_n` low with 2 responses outstanding.
  - `rsp_valid`, `req_ready`, `mem_re` and `mem_we` go to 0 asynchronously.
  - After release, no stale responses appear and the next read returns correct data.
